// File: rtl/snake_vga_pkg.sv
// Shared constants, colours and scheduler state for the snake VGA path.
package snake_vga_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam logic [X_W-1:0] X_MAX = 8'd159;
  localparam logic [Y_W-1:0] Y_MAX = 7'd119;

  localparam logic [C_W-1:0] BLACK  = 3'b000;
  localparam logic [C_W-1:0] BLUE   = 3'b001;
  localparam logic [C_W-1:0] GREEN  = 3'b010;
  localparam logic [C_W-1:0] RED    = 3'b100;
  localparam logic [C_W-1:0] PURPLE = 3'b101;

  typedef enum logic {IDLE, CLEAR} sched_state_e;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x <= X_MAX) && (y <= Y_MAX);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   gidx_o
);
  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    gidx_o  = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        gidx_o       = idx;
      end
    end
  end
endmodule

// File: rtl/vga_plot_scheduler.sv
// Round-robin pixel-port sharer with a full-frame clear engine.
// PLOT_STATS_EN adds drop_count, a saturating count of offscreen transfers.
module vga_plot_scheduler
  import snake_vga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*C_W-1:0] req_colour,
  input  logic                   clear_start,
  input  logic [C_W-1:0]         clear_colour,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic [X_W-1:0]         plot_x,
  output logic [Y_W-1:0]         plot_y,
  output logic [C_W-1:0]         plot_colour,
`ifdef PLOT_STATS_EN
  output logic [15:0]            drop_count,
`endif
  output logic                   plot_en
);
  sched_state_e     state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, gidx;
  logic [NUM_REQ-1:0] grant;
  logic [X_W-1:0]   cx_q, cx_d, px_q, px_d, gx;
  logic [Y_W-1:0]   cy_q, cy_d, py_q, py_d, gy;
  logic [C_W-1:0]   ccol_q, ccol_d, pc_q, pc_d, gc;
  logic             pen_q, pen_d, done_q, done_d;
  logic             xfer, onscr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid_i(req_valid), .ptr_i(ptr_q), .grant_o(grant), .gidx_o(gidx)
  );

  assign gx    = req_x[gidx*X_W +: X_W];
  assign gy    = req_y[gidx*Y_W +: Y_W];
  assign gc    = req_colour[gidx*C_W +: C_W];
  assign onscr = on_screen(gx, gy);

  // clear_start outranks every requester in the cycle it is seen
  assign req_ready = (resetn && state_q == IDLE && !clear_start) ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ccol_d  = ccol_q;
    px_d    = px_q;
    py_d    = py_q;
    pc_d    = pc_q;
    pen_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
          ccol_d  = clear_colour;
        end else if (xfer) begin
          ptr_d = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
          if (onscr) begin
            px_d  = gx;
            py_d  = gy;
            pc_d  = gc;
            pen_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        px_d  = cx_q;
        py_d  = cy_q;
        pc_d  = ccol_q;
        pen_d = 1'b1;
        if (cx_q == X_MAX) begin
          cx_d = '0;
          if (cy_q == Y_MAX) begin
            cy_d    = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ccol_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
      pen_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ccol_q  <= ccol_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
      pen_q   <= pen_d;
      done_q  <= done_d;
    end
  end

  assign plot_x      = px_q;
  assign plot_y      = py_q;
  assign plot_colour = pc_q;
  assign plot_en     = pen_q;
  assign clear_done  = done_q;
  assign clear_busy  = (state_q == CLEAR);

`ifdef PLOT_STATS_EN
  logic [15:0] dcnt_q;
  always_ff @(posedge clk) begin
    if (!resetn)                               dcnt_q <= '0;
    else if (xfer && !onscr && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 1'b1;
  end
  assign drop_count = dcnt_q;
`endif
endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Scoreboard bench: stimulus pushes expected plots, a negedge monitor pops and compares.
module tb_vga_plot_scheduler;
  logic        clk, resetn;
  logic [2:0]  req_valid, req_ready;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic        clear_start, clear_busy, clear_done, plot_en;
  logic [2:0]  clear_colour, plot_colour;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
`ifdef PLOT_STATS_EN
  logic [15:0] drop_count;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       d;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   n_cmp = 0, n_bad = 0, done_cnt = 0, bad;

  vga_plot_scheduler #(.NUM_REQ(3)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
`ifdef PLOT_STATS_EN
    .drop_count(drop_count),
`endif
    .plot_en(plot_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (plot_en) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_plot: got (%0d,%0d,c%0d,done%0b) required none",
                 plot_x, plot_y, plot_colour, clear_done);
      end else begin
        e = expq.pop_front();
        if ({plot_x, plot_y, plot_colour, clear_done} !== e) begin
          n_bad++;
          $display("FAIL plot: got (%0d,%0d,c%0d,done%0b) required (%0d,%0d,c%0d,done%0b)",
                   plot_x, plot_y, plot_colour, clear_done, e.x, e.y, e.c, e.d);
        end
      end
    end else if (clear_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_without_plot: clear_done=1 while plot_en=0");
    end
    if (clear_done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push(input int x, input int y, input int c, input bit d);
    exp_t t;
    t.x = x[7:0];
    t.y = y[6:0];
    t.c = c[2:0];
    t.d = d;
    expq.push_back(t);
  endtask

  task automatic push_clear(input int c);
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        push(xx, yy, c, (xx == 159) && (yy == 119));
  endtask

  int tx[3] = '{10, 20, 30};
  int ty[3] = '{30, 40, 50};
  int tc[3] = '{1, 2, 4};
  int g6[6] = '{0, 0, 0, 2, 0, 2};

  initial begin
    resetn = 1'b0; clear_start = 1'b0; clear_colour = 3'b000;
    req_x = {8'd30, 8'd20, 8'd10};
    req_y = {7'd50, 7'd40, 7'd30};
    req_colour = {3'b100, 3'b010, 3'b001};
    req_valid = 3'b111;
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_plot_en", plot_en, 0);
    chk("rst_plot_xyc", {plot_x, plot_y, plot_colour}, 0);
    chk("rst_busy_done", {clear_busy, clear_done}, 0);
    resetn = 1'b1;

    // 1: all valid, rotating grants 0,1,2,0,1,2
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t1_grant", req_ready, 3'b001 << (i % 3));
      push(tx[i%3], ty[i%3], tc[i%3], 1'b0);
      tick();
    end
    req_valid = 3'b000;
    tick(); tick();
    chk("t1_drained", expq.size(), 0);

    // 2: offscreen sentinel from requester 1
    req_x[8 +: 8] = 8'd255;
    req_y[7 +: 7] = 7'd127;
    req_valid = 3'b010;
    #1;
    chk("t2_ready", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    #1;
    chk("t2_no_plot", plot_en, 0);
`ifdef PLOT_STATS_EN
    chk("t2_drop_count", drop_count, 1);
`endif
    req_x[8 +: 8] = 8'd20;
    req_y[7 +: 7] = 7'd40;
    tick();

    // 3: black clear while requester 2 waits
    req_valid = 3'b100;
    clear_start = 1'b1;
    clear_colour = 3'b000;
    push_clear(0);
    #1;
    chk("t3_start_ready", req_ready, 0);
    tick();
    clear_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (req_ready != 3'b000 || !clear_busy) bad++;
      tick();
    end
    chk("t3_hold_cycles", bad, 0);
    chk("t3_after_ready", req_ready, 3'b100);
    chk("t3_last_flags", {clear_busy, clear_done}, 2'b01);
    chk("t3_last_xy", {plot_x, plot_y}, {8'd159, 7'd119});
    push(30, 50, 4, 1'b0);
    tick();
    req_valid = 3'b000;
    tick(); tick();
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_drained", expq.size(), 0);

    // 4: reset aborts a clear at pixel 5000
    clear_colour = 3'b001;
    clear_start = 1'b1;
    push_clear(1);
    tick();
    clear_start = 1'b0;
    repeat (5000) tick();
    resetn = 1'b0;
    req_valid = 3'b001;
    req_x[0 +: 8] = 8'd1;
    req_y[0 +: 7] = 7'd1;
    req_colour[0 +: 3] = 3'b010;
    #1;
    chk("t4_rst_ready", req_ready, 0);
    tick();
    expq.delete();
    chk("t4_abort_plot_en", plot_en, 0);
    chk("t4_abort_flags", {clear_busy, clear_done}, 0);
    chk("t4_done_cnt", done_cnt, 1);
    resetn = 1'b1;
    #1;
    chk("t4_ready0", req_ready, 3'b001);
    push(1, 1, 2, 1'b0);
    tick();
    chk("t4_latency", {plot_en, plot_x, plot_y}, {1'b1, 8'd1, 7'd1});
    req_valid = 3'b000;
    tick();
    chk("t4_drained", expq.size(), 0);

    // 5: second clear_start mid-sweep is ignored
    clear_colour = 3'b100;
    clear_start = 1'b1;
    push_clear(4);
    tick();
    clear_start = 1'b0;
    repeat (99) tick();
    clear_start = 1'b1;
    clear_colour = 3'b010;
    tick();
    clear_start = 1'b0;
    repeat (19100) tick();
    chk("t5_end_flags", {clear_busy, clear_done}, 2'b01);
    tick(); tick();
    chk("t5_done_cnt", done_cnt, 2);
    chk("t5_drained", expq.size(), 0);

    // 6: requester 2 joins a busy requester 0, pointer starts at 1
    for (int i = 0; i < 6; i++) begin
      req_valid = (i >= 3) ? 3'b101 : 3'b001;
      #1;
      chk("t6_grant", req_ready, 3'b001 << g6[i]);
      if (g6[i] == 0) push(1, 1, 2, 1'b0);
      else            push(30, 50, 4, 1'b0);
      tick();
    end
    req_valid = 3'b000;
    tick(); tick();
    chk("t6_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_plot_scheduler.md
Name: vga_plot_scheduler

Overview:
Shares the single pixel-write port of the VGA adapter between several pixel producers: the snake datapath, the score/title overlay and the game-over banner. Grants are round-robin with a valid/ready handshake, one pixel per clock. A built-in clear engine sweeps the full 160x120 frame with a chosen colour, for reset and restart. Sits between the producers and the vga_adapter x/y/colour/plot inputs.

Parameters:
NUM_REQ, 3, number of pixel requesters; index 0 has highest initial priority.
X_W, 8, x-coordinate width.
Y_W, 7, y-coordinate width.
C_W, 3, colour width (RGB, 1 bit per channel).
X_MAX, 159, last visible column.
Y_MAX, 119, last visible row.

Ports:
clk  in  1  50 MHz system clock
resetn  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester pixel-write request
req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid&ready in the same cycle
req_x  in  NUM_REQ*X_W  packed x-coordinates, requester i at [i*X_W +: X_W]
req_y  in  NUM_REQ*Y_W  packed y-coordinates
req_colour  in  NUM_REQ*C_W  packed colours
clear_start  in  1  one-cycle pulse that starts a full-frame clear
clear_colour  in  C_W  fill colour, sampled on the accepted clear_start
clear_busy  out  1  high while the sweep is in progress
clear_done  out  1  one-cycle pulse after the last clear pixel is issued
plot_x  out  X_W  to vga_adapter x
plot_y  out  Y_W  to vga_adapter y
plot_colour  out  C_W  to vga_adapter colour
plot_en  out  1  to vga_adapter plot

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE, rr pointer=0, plot_en=0, plot_x/plot_y/plot_colour=0, clear_busy=0, clear_done=0. req_ready is 0 while resetn=0. A reset during CLEAR aborts the sweep and does not pulse clear_done.
- States: IDLE (arbitrate), CLEAR (sweep).
- IDLE:
  - req_ready is combinational. At most one bit is set: the first valid requester searching upward from the rr pointer, with wrap-around.
  - On a transfer from requester g, the next cycle drives plot_x/y/colour = req fields of g and plot_en=1. Latency is 1 cycle; throughput is 1 pixel/cycle.
  - rr pointer becomes (g+1) mod NUM_REQ. With no transfer, the pointer holds and plot_en=0 next cycle.
  - The plot_x/y/colour registers hold their last value when plot_en=0.
- Offscreen sentinel: a transfer with x>X_MAX or y>Y_MAX is accepted (ready=1) but produces plot_en=0. The registered coordinates are not updated. The pointer still advances.
- clear_start in IDLE:
  - Has priority over all requests: req_ready=0 that cycle.
  - Latches clear_colour, sets the counters cx=0, cy=0 and enters CLEAR.
- CLEAR:
  - req_ready=0 for all requesters and clear_busy=1.
  - Each cycle issues (cx, cy, latched colour) with plot_en=1 on the next cycle, in row-major order: cx increments; when cx=X_MAX it wraps to 0 and cy increments.
  - After issuing (X_MAX, Y_MAX), returns to IDLE. clear_done=1 and clear_busy=0 on the cycle the last pixel appears on plot_en.
  - The full clear takes exactly 160*120=19200 plot cycles.
  - clear_start during CLEAR is ignored.
- Arbitration state does not change during CLEAR; the rr pointer resumes where it left off.
- The counters are X_W/Y_W wide and must never exceed X_MAX/Y_MAX.

Optional Feature:
- Macro: PLOT_STATS_EN.
- Defined: adds output port drop_count [15:0]. It counts accepted offscreen sentinel transfers, saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent, and the offscreen drop is silent. All other behaviour is identical.

Decomposition:
- Package snake_vga_pkg holds: X_W, Y_W, C_W, X_MAX, Y_MAX; colour constants BLACK=000, BLUE=001, GREEN=010, RED=100, PURPLE=101; a scheduler state enum (IDLE, CLEAR).
- Sub-module rr_arbiter, parameterised by NUM_REQ: inputs valid vector, pointer; outputs one-hot grant and grant index. It is purely combinational; the pointer register lives in vga_plot_scheduler.

Test Plan:
1. All three requesters valid for 6 cycles, fixed coordinates (10,30), (20,40), (30,50) -> grants 0,1,2,0,1,2. plot_en=1 for 6 consecutive cycles, each one cycle after its grant, with matching coordinates.
2. Only requester 1 valid, with x=255, y=127 -> req_ready[1]=1 and plot_en stays 0. With PLOT_STATS_EN, drop_count increments by 1.
3. clear_start with clear_colour=000 while requester 2 is valid -> req_ready=0 for 19200 cycles. First plot is (0,0), pixel 161 is (0,1), last is (159,119). clear_done pulses exactly once with the last plot. Requester 2 is granted the following cycle.
4. Assert resetn=0 at clear pixel 5000 -> next cycle plot_en=0, clear_busy=0, no clear_done. After release, a requester-0 pixel (1,1) plots with latency 1.
5. clear_start pulsed again at pixel 100 of an active clear -> ignored. The sweep ends at 19200 plots with a single clear_done.
6. Requester 0 continuously valid and requester 2 valid from cycle 3 -> requester 2 is granted within NUM_REQ cycles, with no starvation.
